taxi_meter_ctrl: RTL

TAXI_METER_CTRL -- requirements
Module: taxi_meter_ctrl

---
 rtl/taxi_meter_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/taxi_meter_ctrl.sv
// Taxi meter controller: trip distance, fare and waiting-time accounting.
// States are IDLE, RUN, WAIT and STOP. Every output except point is registered.
module taxi_meter_ctrl #(
  parameter int unsigned BASE_FARE   = 100,
  parameter int unsigned BASE_DIST   = 30,
  parameter int unsigned DIST_RATE   = 2,
  parameter int unsigned IDLE_THRESH = 5,
  parameter int unsigned WAIT_UNIT   = 60,
  parameter int unsigned WAIT_RATE   = 10,
  parameter int unsigned MAX_VAL     = 9999
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        key_start,
  input  logic        key_stop,
  input  logic        wheel_pulse,
  input  logic        tick_1s,
  output logic [1:0]  state,
  output logic [15:0] data_km,
  output logic [15:0] data_fare,
  output logic [15:0] wait_sec,
  output logic [3:0]  point
);

  localparam int unsigned DW     = 16;
  localparam int unsigned IDLE_W = $clog2(IDLE_THRESH + 1);
  localparam int unsigned WSEC_W = $clog2(WAIT_UNIT + 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     km_q, km_d;
  logic [DW-1:0]     fare_q, fare_d;
  logic [DW-1:0]     ws_q, ws_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WSEC_W-1:0] wsec_q, wsec_d;
  logic              wrapped_q, wrapped_d;
  logic [IDLE_W-1:0] idle_inc;
  logic [WSEC_W-1:0] wsec_inc;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > (DW+1)'(MAX_VAL)) return DW'(MAX_VAL);
    return s[DW-1:0];
  endfunction

  assign idle_inc = idle_q + IDLE_W'(1);
  assign wsec_inc = wsec_q + WSEC_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    km_d      = km_q;
    fare_d    = fare_q;
    ws_d      = ws_q;
    idle_d    = idle_q;
    wsec_d    = wsec_q;
    wrapped_d = wrapped_q;
    case (state_q)
      S_IDLE, S_STOP: begin
        if (key_start) begin
          state_d   = S_RUN;
          km_d      = '0;
          fare_d    = DW'(BASE_FARE);
          ws_d      = '0;
          idle_d    = '0;
          wsec_d    = '0;
          wrapped_d = 1'b0;
        end
      end
      default: begin
        if (wheel_pulse) begin
          // Once the odometer has wrapped, every further pulse is chargeable
          if (km_q >= DW'(BASE_DIST) || wrapped_q) fare_d = sat_add(fare_q, DW'(DIST_RATE));
          if (km_q >= DW'(MAX_VAL)) begin
            km_d      = '0;
            wrapped_d = 1'b1;
          end else begin
            km_d = km_q + DW'(1);
          end
          idle_d  = '0;
          state_d = S_RUN;
        end else if (tick_1s && state_q == S_RUN) begin
          if (idle_inc >= IDLE_W'(IDLE_THRESH)) begin
            idle_d  = '0;
            state_d = S_WAIT;
          end else begin
            idle_d = idle_inc;
          end
        end
        if (tick_1s && state_q == S_WAIT) begin
          if (ws_q != {DW{1'b1}}) ws_d = ws_q + DW'(1);
          if (wsec_inc >= WSEC_W'(WAIT_UNIT)) begin
            wsec_d = '0;
            fare_d = sat_add(fare_d, DW'(WAIT_RATE));
          end else begin
            wsec_d = wsec_inc;
          end
        end
        if (key_stop) state_d = S_STOP;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q   <= S_IDLE;
      km_q      <= '0;
      fare_q    <= '0;
      ws_q      <= '0;
      idle_q    <= '0;
      wsec_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      km_q      <= km_d;
      fare_q    <= fare_d;
      ws_q      <= ws_d;
      idle_q    <= idle_d;
      wsec_q    <= wsec_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign state     = state_q;
  assign data_km   = km_q;
  assign data_fare = fare_q;
  assign wait_sec  = ws_q;
  assign point     = 4'b0010;

endmodule
